// File: rtl/ysyx_24090018_exu_ctrl_pkg.sv
// Shared types for the NPC multi-cycle sequencer: state encoding and reset PC.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package ysyx_24090018_exu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF_REQ   = 3'd0,
    ST_IF_WAIT  = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_WB       = 3'd5,
    ST_HALT     = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  // States in which the sequencer is blocked on an external handshake;
  // only these are subject to the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_IF_REQ) || (s == ST_IF_WAIT) ||
           (s == ST_MEM_REQ) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_24090018_wdog.sv
// Wait-state watchdog: counts enabled cycles, flags the last allowed one.
// Latency: expire is combinational from the count (flags cycle TIMEOUT_CYC of a wait).
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst (sync, active-high), clear, enable in; expire out.
module ysyx_24090018_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The owner leaves the wait state when this fires, so cnt never runs past it.
  assign expire = enable && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ysyx_24090018_exu_ctrl.sv
// Multi-cycle NPC sequencer: fetch, hold inst, execute, optional LSU access, writeback.
// Latency: ALU instruction 3 cycles, load/store 4 cycles with zero-wait IFU/LSU.
// Backpressure: ifu/lsu requests held until ready; any wait longer than TIMEOUT_CYC -> ERR.
// Ports: IFU req/addr/ready/rvalid/rdata; decode flags + jump target from IDU/EXU;
//        LSU req/ready/rvalid; rf_we/retire pulses; sticky halt/err status; inst/pc out.
module ysyx_24090018_exu_ctrl
  import ysyx_24090018_exu_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(RESET_PC_DEF),
  parameter int                    TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_o,
  output logic [DATA_WIDTH-1:0] ifu_addr_o,
  input  logic                  ifu_ready_i,
  input  logic                  ifu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] ifu_rdata_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic                  is_jump_i,
  input  logic                  rd_wen_i,
  input  logic                  ebreak_i,
  input  logic [DATA_WIDTH-1:0] jump_addr_i,
  output logic                  lsu_req_o,
  input  logic                  lsu_ready_i,
  input  logic                  lsu_rvalid_i,
  output logic                  rf_we_o,
  output logic                  retire_o,
  output logic                  halt_o,
  output logic                  err_o
);

  state_t state, state_nxt;
  logic   fetch_done;
  logic   expire;
  logic   jump_lsb_unused;

  // Jump targets are forced to halfword alignment; bit 0 is dropped.
  assign jump_lsb_unused = jump_addr_i[0];

  ysyx_24090018_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_nxt != state),
    .enable (is_wait_state(state)),
    .expire (expire)
  );

  // Next state. A handshake on the expiring cycle takes the normal path.
  always_comb begin
    state_nxt  = state;
    fetch_done = 1'b0;
    case (state)
      ST_IF_REQ: begin
        if (ifu_ready_i) begin
          if (ifu_rvalid_i) begin
            fetch_done = 1'b1;
            state_nxt  = ST_EXEC;
          end else begin
            state_nxt  = ST_IF_WAIT;
          end
        end else if (expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_IF_WAIT: begin
        if (ifu_rvalid_i) begin
          fetch_done = 1'b1;
          state_nxt  = ST_EXEC;
        end else if (expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_EXEC: begin
        if (ebreak_i) begin
          state_nxt = ST_HALT;
        end else if (is_load_i || is_store_i) begin
          state_nxt = ST_MEM_REQ;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        if (lsu_ready_i) begin
          state_nxt = lsu_rvalid_i ? ST_WB : ST_MEM_WAIT;
        end else if (expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_MEM_WAIT: begin
        if (lsu_rvalid_i) begin
          state_nxt = ST_WB;
        end else if (expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_WB:   state_nxt = ST_IF_REQ;
      ST_HALT: state_nxt = ST_HALT;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IF_REQ;
      pc_o   <= RESET_PC;
      inst_o <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_done) begin
        inst_o <= ifu_rdata_i;
      end
      if (state == ST_WB) begin
        pc_o <= is_jump_i ? {jump_addr_i[DATA_WIDTH-1:1], 1'b0}
                          : pc_o + DATA_WIDTH'(4);
      end
    end
  end

  assign ifu_req_o  = (state == ST_IF_REQ);
  assign ifu_addr_o = pc_o;
  assign lsu_req_o  = (state == ST_MEM_REQ);
  assign retire_o   = (state == ST_WB);
  assign rf_we_o    = (state == ST_WB) && rd_wen_i && !is_store_i;
  assign halt_o     = (state == ST_HALT);
  assign err_o      = (state == ST_ERR);

endmodule

// File: tb/tb_ysyx_24090018_exu_ctrl.sv
// Bench for the NPC sequencer: drives IFU/LSU/decode, compares every cycle against
// a transaction-script model (what each cycle of an instruction must look like).
module tb_ysyx_24090018_exu_ctrl;

  localparam int          T      = 8;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk, rst;
  logic        ifu_req_o, ifu_ready_i, ifu_rvalid_i;
  logic [31:0] ifu_addr_o, ifu_rdata_i, inst_o, pc_o, jump_addr_i;
  logic        is_load_i, is_store_i, is_jump_i, rd_wen_i, ebreak_i;
  logic        lsu_req_o, lsu_ready_i, lsu_rvalid_i;
  logic        rf_we_o, retire_o, halt_o, err_o;

  ysyx_24090018_exu_ctrl #(
    .DATA_WIDTH  (32),
    .RESET_PC    (RST_PC),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_o    (ifu_req_o),
    .ifu_addr_o   (ifu_addr_o),
    .ifu_ready_i  (ifu_ready_i),
    .ifu_rvalid_i (ifu_rvalid_i),
    .ifu_rdata_i  (ifu_rdata_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .is_jump_i    (is_jump_i),
    .rd_wen_i     (rd_wen_i),
    .ebreak_i     (ebreak_i),
    .jump_addr_i  (jump_addr_i),
    .lsu_req_o    (lsu_req_o),
    .lsu_ready_i  (lsu_ready_i),
    .lsu_rvalid_i (lsu_rvalid_i),
    .rf_we_o      (rf_we_o),
    .retire_o     (retire_o),
    .halt_o       (halt_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dut_retires = 0;
  int m_retires   = 0;

  // Model: expected outputs for the current cycle.
  logic        e_ifu_req, e_lsu_req, e_rf_we, e_retire, e_halt, e_err;
  logic [31:0] m_pc, m_inst;
  bit          chk_en = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk1 ("ifu_req", ifu_req_o, e_ifu_req);
      chk32("ifu_addr", ifu_addr_o, m_pc);
      chk32("pc", pc_o, m_pc);
      chk32("inst", inst_o, m_inst);
      chk1 ("lsu_req", lsu_req_o, e_lsu_req);
      chk1 ("rf_we", rf_we_o, e_rf_we);
      chk1 ("retire", retire_o, e_retire);
      chk1 ("halt", halt_o, e_halt);
      chk1 ("err", err_o, e_err);
      if (retire_o === 1'b1) dut_retires++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic exp_idle();
    e_ifu_req = 0; e_lsu_req = 0; e_rf_we = 0; e_retire = 0; e_halt = 0; e_err = 0;
  endtask

  task automatic noise_ifu();
    ifu_ready_i  = 1'($urandom_range(0, 1));
    ifu_rvalid_i = 1'($urandom_range(0, 1));
    ifu_rdata_i  = $urandom;
  endtask

  task automatic noise_lsu();
    lsu_ready_i  = 1'($urandom_range(0, 1));
    lsu_rvalid_i = 1'($urandom_range(0, 1));
  endtask

  task automatic noise_decode();
    is_load_i   = 1'($urandom_range(0, 1));
    is_store_i  = 1'($urandom_range(0, 1));
    is_jump_i   = 1'($urandom_range(0, 1));
    rd_wen_i    = 1'($urandom_range(0, 1));
    ebreak_i    = 1'($urandom_range(0, 1));
    jump_addr_i = $urandom;
  endtask

  task automatic set_if(input bit mem, input logic rdy, input logic vld, input logic [31:0] d);
    if (mem) begin
      lsu_ready_i = rdy; lsu_rvalid_i = vld; noise_ifu();
    end else begin
      ifu_ready_i = rdy; ifu_rvalid_i = vld; ifu_rdata_i = d; noise_lsu();
    end
  endtask

  // One request/response exchange: ready after rd request cycles, rvalid vd cycles
  // after that (0 = same cycle). Any wait of T cycles without the event times out.
  task automatic hs(input bit mem, input int rd, input int vd, input logic [31:0] data,
                    output bit to);
    to = 0;
    for (int c = 0; c < T; c++) begin
      exp_idle();
      if (mem) e_lsu_req = 1; else e_ifu_req = 1;
      if (c == rd) begin
        set_if(mem, 1'b1, vd == 0, (vd == 0) ? data : $urandom);
        tick();
        break;
      end
      set_if(mem, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      tick();
      if (c == T - 1) begin
        to = 1;
        return;
      end
    end
    if (vd == 0) return;
    for (int k = 1; k <= T; k++) begin
      exp_idle();
      set_if(mem, 1'($urandom_range(0, 1)), k == vd, (k == vd) ? data : $urandom);
      tick();
      if (k == vd) return;
    end
    to = 1;
  endtask

  task automatic sticky(input bit is_err);
    for (int i = 0; i < 6; i++) begin
      exp_idle();
      if (is_err) e_err = 1; else e_halt = 1;
      noise_ifu(); noise_lsu(); noise_decode();
      tick();
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst = 1;
    noise_ifu(); noise_lsu(); noise_decode();
    tick();
    tick();
    chk32("rst_pc", pc_o, RST_PC);
    chk32("rst_inst", inst_o, 32'h0);
    chk1 ("rst_ifu_req", ifu_req_o, 1'b1);
    chk1 ("rst_lsu_req", lsu_req_o, 1'b0);
    chk1 ("rst_retire", retire_o, 1'b0);
    chk1 ("rst_halt", halt_o, 1'b0);
    chk1 ("rst_err", err_o, 1'b0);
    rst = 0;
    m_pc = RST_PC;
    m_inst = 32'h0;
    chk_en = 1;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 jump, 4 ebreak
  task automatic run_instr(input int kind, input int frd, input int fvd, input int mrd,
                           input int mvd, input logic [31:0] jt, input logic wen,
                           output bit stop);
    logic [31:0] instr;
    bit to;
    stop = 0;
    instr = $urandom;
    noise_decode();
    hs(1'b0, frd, fvd, instr, to);
    if (to) begin
      sticky(1'b1);
      stop = 1;
      return;
    end
    m_inst = instr;
    is_load_i   = (kind == 1);
    is_store_i  = (kind == 2);
    is_jump_i   = (kind == 3);
    ebreak_i    = (kind == 4);
    rd_wen_i    = wen;
    jump_addr_i = (kind == 3) ? jt : $urandom;
    exp_idle();
    noise_ifu(); noise_lsu();
    tick();
    if (kind == 4) begin
      sticky(1'b0);
      stop = 1;
      return;
    end
    if (kind == 1 || kind == 2) begin
      hs(1'b1, mrd, mvd, 32'h0, to);
      if (to) begin
        sticky(1'b1);
        stop = 1;
        return;
      end
    end
    exp_idle();
    e_retire = 1;
    e_rf_we  = wen & (kind != 2);
    noise_ifu(); noise_lsu();
    tick();
    m_retires++;
    m_pc = (kind == 3) ? {jt[31:1], 1'b0} : m_pc + 32'd4;
  endtask

  function automatic int rdelay();
    return ($urandom_range(0, 19) == 0) ? int'($urandom_range(6, 9))
                                        : int'($urandom_range(0, 3));
  endfunction

  initial begin
    bit stop;
    int c0;
    rst = 1;
    ifu_ready_i = 0; ifu_rvalid_i = 0; ifu_rdata_i = 0;
    lsu_ready_i = 0; lsu_rvalid_i = 0;
    is_load_i = 0; is_store_i = 0; is_jump_i = 0; rd_wen_i = 0; ebreak_i = 0;
    jump_addr_i = 0;
    exp_idle();
    m_pc = RST_PC; m_inst = 0;
    @(posedge clk);
    #1;

    // Zero-wait ALU stream: sequential fetch addresses, 3 cycles per instruction.
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      chk32("t1_fetch_addr", ifu_addr_o, RST_PC + 32'(4 * i));
      run_instr(0, 0, 0, 0, 0, 32'h0, 1'b1, stop);
    end
    chk32("t1_cycles", 32'(cyc - c0), 32'd9);
    chk32("t1_pc", pc_o, 32'h8000_000C);

    // Slow IFU: ready after 2, data 3 later.
    run_instr(0, 2, 3, 0, 0, 32'h0, 1'b1, stop);

    // Late load, then zero-wait store.
    run_instr(1, 0, 0, 0, 5, 32'h0, 1'b1, stop);
    run_instr(2, 0, 0, 1, 0, 32'h0, 1'b1, stop);

    // Jump alignment and PC wrap.
    run_instr(3, 0, 0, 0, 0, 32'h8000_0101, 1'b1, stop);
    chk32("t4_jump_addr", ifu_addr_o, 32'h8000_0100);
    run_instr(3, 1, 1, 0, 0, 32'hFFFF_FFFD, 1'b0, stop);
    chk32("t4_pre_wrap", pc_o, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, 0, 0, 32'h0, 1'b1, stop);
    chk32("t4_wrap", pc_o, 32'h0);

    // ebreak halts until reset.
    run_instr(4, 0, 0, 0, 0, 32'h0, 1'b0, stop);
    chk1("t5_halt", halt_o, 1'b1);
    chk1("t5_no_err", err_o, 1'b0);
    do_reset();

    // Fetch timeout boundary: ready on the last allowed cycle is fine, one later is not.
    run_instr(0, T - 1, 0, 0, 0, 32'h0, 1'b1, stop);
    chk1("t6_no_err", err_o, 1'b0);
    run_instr(0, T, 0, 0, 0, 32'h0, 1'b1, stop);
    chk1("t6_err", err_o, 1'b1);
    chk1("t6_no_halt", halt_o, 1'b0);
    do_reset();
    run_instr(1, 0, 0, 0, T + 1, 32'h0, 1'b1, stop);
    chk1("t6_lsu_err", err_o, 1'b1);
    do_reset();

    // Random program.
    for (int n = 0; n < 300; n++) begin
      int r, kind;
      r = int'($urandom_range(0, 49));
      kind = (r == 0) ? 4 : (r <= 10) ? 1 : (r <= 20) ? 2 : (r <= 30) ? 3 : 0;
      run_instr(kind, rdelay(), rdelay(), rdelay(), rdelay(), $urandom,
                1'($urandom_range(0, 1)), stop);
      if (stop) do_reset();
    end

    chk_en = 0;
    chk32("retire_count", 32'(dut_retires), 32'(m_retires));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
